// File: rtl/mem_port_arbiter.sv
// N-channel memory port arbiter: merges requesters onto one memory port and
// routes in-order responses back to the issuing channel through a tag FIFO.
module mem_port_arbiter #(
    parameter int N_CH    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4,
    parameter int ARB_RR  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH-1:0]           ch_req_valid,
    output logic [N_CH-1:0]           ch_req_ready,
    input  logic [N_CH*AW-1:0]        ch_req_addr,
    input  logic [N_CH*DW-1:0]        ch_req_data,
    input  logic [N_CH*2-1:0]         ch_req_fcn,
    input  logic [N_CH*3-1:0]         ch_req_typ,
    output logic [N_CH-1:0]           ch_res_valid,
    output logic [DW-1:0]             ch_res_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [AW-1:0]             mem_req_addr,
    output logic [DW-1:0]             mem_req_data,
    output logic [1:0]                mem_req_fcn,
    output logic [2:0]                mem_req_typ,
    input  logic                      mem_res_valid,
    input  logic [DW-1:0]             mem_res_data,
    output logic [$clog2(MAX_OUT):0]  outstanding,
    output logic                      err_orphan
);

    localparam int TW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW    = $clog2(MAX_OUT) + 1;
    localparam int DEPTH = 1 << PW;

    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] winner;
    logic [TW-1:0] tag_fifo [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [TW-1:0] head_tag;
    logic          any_valid;
    logic          can_issue;
    logic          push;
    logic          pop;
    logic [TW:0]   rot_sum;
    logic [TW-1:0] idx;
    logic          found;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [1:0]    sel_fcn;
    logic [2:0]    sel_typ;

    // Search order starts at rr_ptr in round-robin mode, at channel 0 otherwise.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        rot_sum = '0;
        idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ARB_RR != 0) begin
                rot_sum = {1'b0, rr_ptr} + (TW+1)'(i);
                if (rot_sum >= (TW+1)'(N_CH))
                    rot_sum = rot_sum - (TW+1)'(N_CH);
                idx = rot_sum[TW-1:0];
            end else begin
                idx = TW'(i);
            end
            if (!found && ch_req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_fcn  = '0;
        sel_typ  = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (winner == TW'(j)) begin
                sel_addr = ch_req_addr[j*AW +: AW];
                sel_data = ch_req_data[j*DW +: DW];
                sel_fcn  = ch_req_fcn[j*2 +: 2];
                sel_typ  = ch_req_typ[j*3 +: 3];
            end
        end
    end

    assign head_tag  = tag_fifo[rd_ptr];
    assign any_valid = |ch_req_valid;
    assign pop       = mem_res_valid && (outstanding != '0);
    // A response retiring this cycle frees a slot, so a full FIFO can still issue.
    assign can_issue = (outstanding < CW'(MAX_OUT)) || pop;
    assign mem_req_valid = any_valid && can_issue && !reset;
    assign push      = mem_req_valid && mem_req_ready;

    assign mem_req_addr = mem_req_valid ? sel_addr : '0;
    assign mem_req_data = mem_req_valid ? sel_data : '0;
    assign mem_req_fcn  = mem_req_valid ? sel_fcn  : '0;
    assign mem_req_typ  = mem_req_valid ? sel_typ  : '0;
    assign ch_res_data  = pop ? mem_res_data : '0;

    always_comb begin
        ch_req_ready = '0;
        ch_res_valid = '0;
        for (int j = 0; j < N_CH; j++) begin
            ch_req_ready[j] = push && (winner == TW'(j));
            ch_res_valid[j] = pop && (head_tag == TW'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_fifo[wr_ptr] <= winner;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            err_orphan  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (ARB_RR != 0) begin
                    if (winner == TW'(N_CH - 1))
                        rr_ptr <= '0;
                    else
                        rr_ptr <= winner + 1'b1;
                end
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            outstanding <= outstanding + CW'(push) - CW'(pop);
            if (mem_res_valid && (outstanding == '0))
                err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance and a
// fixed-priority instance share stimulus; response tags come from a scoreboard queue.
module tb_mem_port_arbiter;

    localparam int N_CH = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_OUT = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_CH-1:0]      ch_req_valid;
    logic [N_CH*AW-1:0]   ch_req_addr;
    logic [N_CH*DW-1:0]   ch_req_data;
    logic [N_CH*2-1:0]    ch_req_fcn;
    logic [N_CH*3-1:0]    ch_req_typ;
    logic                 mem_req_ready;
    logic                 mem_res_valid;
    logic [DW-1:0]        mem_res_data;

    logic [N_CH-1:0] ch_req_ready, fx_ch_req_ready;
    logic [N_CH-1:0] ch_res_valid, fx_ch_res_valid;
    logic [DW-1:0]   ch_res_data, fx_ch_res_data;
    logic            mem_req_valid, fx_mem_req_valid;
    logic [AW-1:0]   mem_req_addr, fx_mem_req_addr;
    logic [DW-1:0]   mem_req_data, fx_mem_req_data;
    logic [1:0]      mem_req_fcn, fx_mem_req_fcn;
    logic [2:0]      mem_req_typ, fx_mem_req_typ;
    logic [2:0]      outstanding, fx_outstanding;
    logic            err_orphan, fx_err_orphan;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int fx_q[$];
    int exp_rr;
    int tag;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT), .ARB_RR(1)) dut (
        .clk(clk), .reset(reset),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
        .ch_req_addr(ch_req_addr), .ch_req_data(ch_req_data),
        .ch_req_fcn(ch_req_fcn), .ch_req_typ(ch_req_typ),
        .ch_res_valid(ch_res_valid), .ch_res_data(ch_res_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ),
        .mem_res_valid(mem_res_valid), .mem_res_data(mem_res_data),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    mem_port_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT), .ARB_RR(0)) fx (
        .clk(clk), .reset(reset),
        .ch_req_valid(ch_req_valid), .ch_req_ready(fx_ch_req_ready),
        .ch_req_addr(ch_req_addr), .ch_req_data(ch_req_data),
        .ch_req_fcn(ch_req_fcn), .ch_req_typ(ch_req_typ),
        .ch_res_valid(fx_ch_res_valid), .ch_res_data(fx_ch_res_data),
        .mem_req_valid(fx_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(fx_mem_req_addr), .mem_req_data(fx_mem_req_data),
        .mem_req_fcn(fx_mem_req_fcn), .mem_req_typ(fx_mem_req_typ),
        .mem_res_valid(mem_res_valid), .mem_res_data(mem_res_data),
        .outstanding(fx_outstanding), .err_orphan(fx_err_orphan)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        ch_req_valid  = '0;
        ch_req_addr   = '0;
        ch_req_data   = '0;
        ch_req_fcn    = '0;
        ch_req_typ    = '0;
        mem_req_ready = 1'b1;
        mem_res_valid = 1'b0;
        mem_res_data  = '0;
    endtask

    task automatic set_req(input int ch, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] fcn, input logic [2:0] typ);
        ch_req_addr[ch*AW +: AW] = addr;
        ch_req_data[ch*DW +: DW] = data;
        ch_req_fcn[ch*2 +: 2]    = fcn;
        ch_req_typ[ch*3 +: 3]    = typ;
    endtask

    // Compare the round-robin instance's response against the scoreboard head.
    task automatic chk_resp(input string name, input logic [31:0] data);
        if (exp_q.size() == 0) begin
            chk({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            tag = exp_q.pop_front();
            chk({name, "_res_valid"}, 64'(ch_res_valid), 64'(1 << tag));
            chk({name, "_res_data"}, 64'(ch_res_data), 64'(data));
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        exp_rr = 0;

        // Reset state, including forced-idle request outputs under active valid.
        step();
        step();
        ch_req_valid = 2'b11;
        #1;
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_ch_req_ready", 64'(ch_req_ready), 64'd0);
        ch_req_valid = 2'b00;
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan), 64'd0);
        chk("rst_ch_res_valid", 64'(ch_res_valid), 64'd0);
        chk("rst_ch_res_data", 64'(ch_res_data), 64'd0);
        chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);

        // Single-channel read.
        step();
        reset = 1'b0;
        set_req(0, 32'h100, 32'h0, 2'd0, 3'd2);
        ch_req_valid = 2'b01;
        #1;
        chk("rd_mem_req_valid", 64'(mem_req_valid), 64'd1);
        chk("rd_mem_req_addr", 64'(mem_req_addr), 64'h100);
        chk("rd_mem_req_fcn", 64'(mem_req_fcn), 64'd0);
        chk("rd_mem_req_typ", 64'(mem_req_typ), 64'd2);
        chk("rd_ch_req_ready", 64'(ch_req_ready), 64'b01);
        exp_q.push_back(0);
        fx_q.push_back(0);
        exp_rr = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            ch_req_valid = 2'b00;
            #1;
            chk("rd_outstanding_hold", 64'(outstanding), 64'd1);
            chk("rd_no_early_res", 64'(ch_res_valid), 64'd0);
        end
        step();
        mem_res_valid = 1'b1;
        mem_res_data = 32'hDEADBEEF;
        #1;
        chk_resp("rd", 32'hDEADBEEF);
        void'(fx_q.pop_front());
        step();
        mem_res_valid = 1'b0;
        #1;
        chk("rd_outstanding_done", 64'(outstanding), 64'd0);
        chk("rd_err_orphan", 64'(err_orphan), 64'd0);

        // Interleaved routing: ch1, ch0, ch1 with distinct fields.
        set_req(0, 32'h200, 32'hA5, 2'd1, 3'd3);
        set_req(1, 32'h300, 32'h5A, 2'd0, 3'd1);
        ch_req_valid = 2'b10;
        #1;
        chk("il_grant0", 64'(ch_req_ready), 64'b10);
        chk("il_addr0", 64'(mem_req_addr), 64'h300);
        exp_q.push_back(1);
        step();
        ch_req_valid = 2'b01;
        #1;
        chk("il_grant1", 64'(ch_req_ready), 64'b01);
        chk("il_data1", 64'(mem_req_data), 64'hA5);
        chk("il_fcn1", 64'(mem_req_fcn), 64'd1);
        chk("il_typ1", 64'(mem_req_typ), 64'd3);
        exp_q.push_back(0);
        step();
        ch_req_valid = 2'b10;
        #1;
        chk("il_grant2", 64'(ch_req_ready), 64'b10);
        exp_q.push_back(1);
        exp_rr = 0;
        step();
        ch_req_valid = 2'b00;
        #1;
        chk("il_outstanding", 64'(outstanding), 64'd3);
        for (int k = 1; k <= 3; k++) begin
            mem_res_valid = 1'b1;
            mem_res_data = 32'(k);
            #1;
            chk_resp("il", 32'(k));
            step();
        end
        mem_res_valid = 1'b0;
        #1;
        chk("il_outstanding_done", 64'(outstanding), 64'd0);

        // Fairness: both valid, responses returned the cycle after each issue.
        ch_req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) ch_req_valid = 2'b00;
            mem_res_valid = (k > 0);
            mem_res_data = 32'h40 + 32'(k);
            #1;
            if (k < 4) begin
                chk("rr_grant", 64'(ch_req_ready), 64'(1 << exp_rr));
                chk("fx_grant", 64'(fx_ch_req_ready), 64'b01);
            end
            if (k > 0) begin
                chk_resp("rr", 32'h40 + 32'(k));
                chk("fx_res_valid", 64'(fx_ch_res_valid), 64'b01);
            end
            if (k < 4) begin
                exp_q.push_back(exp_rr);
                exp_rr = (exp_rr + 1) % N_CH;
            end
            step();
        end
        mem_res_valid = 1'b0;
        #1;
        chk("rr_outstanding_done", 64'(outstanding), 64'd0);

        // Full stall at MAX_OUT.
        set_req(0, 32'h400, 32'h0, 2'd0, 3'd0);
        ch_req_valid = 2'b01;
        for (int k = 0; k < MAX_OUT; k++) begin
            #1;
            chk("full_accept", 64'(ch_req_ready), 64'b01);
            exp_q.push_back(0);
            step();
        end
        exp_rr = 1;
        #1;
        chk("full_stall_valid", 64'(mem_req_valid), 64'd0);
        chk("full_stall_ready", 64'(ch_req_ready), 64'd0);
        chk("full_stall_addr", 64'(mem_req_addr), 64'd0);
        chk("full_outstanding", 64'(outstanding), 64'(MAX_OUT));
        step();
        mem_res_valid = 1'b1;
        mem_res_data = 32'h55;
        #1;
        chk("full_issue_on_pop", 64'(mem_req_valid), 64'd1);
        chk("full_ready_on_pop", 64'(ch_req_ready), 64'b01);
        chk_resp("full", 32'h55);
        exp_q.push_back(0);
        step();
        ch_req_valid = 2'b00;
        mem_res_valid = 1'b0;
        #1;
        chk("full_outstanding_hold", 64'(outstanding), 64'(MAX_OUT));
        for (int k = 0; k < MAX_OUT; k++) begin
            mem_res_valid = 1'b1;
            mem_res_data = 32'h60 + 32'(k);
            #1;
            chk_resp("drain", 32'h60 + 32'(k));
            step();
        end
        mem_res_valid = 1'b0;
        #1;
        chk("drain_outstanding", 64'(outstanding), 64'd0);
        chk("drain_no_orphan", 64'(err_orphan), 64'd0);

        // Reset mid-flight with two requests in flight (rr_ptr would be 1 afterwards).
        ch_req_valid = 2'b01;
        step();
        step();
        ch_req_valid = 2'b00;
        #1;
        chk("mid_outstanding", 64'(outstanding), 64'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        exp_rr = 0;
        #1;
        chk("mid_outstanding_cleared", 64'(outstanding), 64'd0);
        chk("mid_err_clear", 64'(err_orphan), 64'd0);

        // Orphan response after reset.
        mem_res_valid = 1'b1;
        mem_res_data = 32'h99;
        #1;
        chk("orphan_no_res", 64'(ch_res_valid), 64'd0);
        step();
        mem_res_valid = 1'b0;
        #1;
        chk("orphan_set", 64'(err_orphan), 64'd1);
        chk("orphan_outstanding", 64'(outstanding), 64'd0);
        ch_req_valid = 2'b11;
        #1;
        chk("mid_rr_ptr_zero", 64'(ch_req_ready), 64'b01);
        exp_q.push_back(0);
        step();
        ch_req_valid = 2'b00;
        mem_res_valid = 1'b1;
        mem_res_data = 32'h77;
        #1;
        chk_resp("post_rst", 32'h77);
        step();
        mem_res_valid = 1'b0;
        step();
        #1;
        chk("orphan_sticky", 64'(err_orphan), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("orphan_cleared", 64'(err_orphan), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-channel memory port arbiter for the ncore pipeline. It merges up to N_CH independent requesters (fetch, load/store, future DMA/debug) onto one memory port. It carries the existing MemoryRequest fields (addr, data, fcn, typ) with valid/ready request and valid-only response handshakes. It tracks in-flight requests in an in-order tag FIFO so each response returns to the channel that issued it. Round-robin or fixed-priority arbitration is selected by parameter.

## Interface
- N_CH, 2: number of requesting channels (1..8); channel 0 is highest priority in fixed mode.
- AW, 32: address width.
- DW, 32: data width.
- MAX_OUT, 4: maximum outstanding requests (tag FIFO depth, power of two, 1..16).
- ARB_RR, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ch_req_valid  in  N_CH  per-channel request valid.
- ch_req_ready  out  N_CH  per-channel request accepted this cycle.
- ch_req_addr  in  N_CH*AW  packed addresses; channel i at bits [i*AW +: AW].
- ch_req_data  in  N_CH*DW  packed write data.
- ch_req_fcn  in  N_CH*2  MemoryWriteSignal encoding (0 = M_XRD, 1 = M_XWR).
- ch_req_typ  in  N_CH*3  MemoryMaskType encoding.
- ch_res_valid  out  N_CH  one-hot response strobe.
- ch_res_data  out  DW  response data, broadcast to all channels.
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream accepts.
- mem_req_addr / mem_req_data / mem_req_fcn / mem_req_typ  out  AW / DW / 2 / 3  selected channel's fields.
- mem_res_valid  in  1  downstream response strobe; responses arrive in request order.
- mem_res_data  in  DW  downstream response data.
- outstanding  out  $clog2(MAX_OUT)+1  current in-flight count.
- err_orphan  out  1  sticky; a response arrived with no request in flight.

## Operation
- Every accepted request yields exactly one mem_res_valid pulse, for both reads and writes.
- Arbitration:
  - Candidates are channels with ch_req_valid=1.
  - ARB_RR=1: search starts at rr_ptr and wraps modulo N_CH; first valid channel wins.
  - ARB_RR=0: lowest valid index wins.
- can_issue = (outstanding < MAX_OUT) || pop, where pop = mem_res_valid && outstanding != 0.
- mem_req_valid = any ch_req_valid && can_issue. mem_req_* carry the winning channel's fields.
- When mem_req_valid=0, mem_req_* outputs are 0.
- ch_req_ready[i] = (winner == i) && can_issue && mem_req_ready. At most one bit is set.
- Accept (push) = mem_req_valid && mem_req_ready.
  - Push the winner index into the tag FIFO.
  - ARB_RR=1: rr_ptr <= (winner+1) mod N_CH. rr_ptr is unchanged when nothing is accepted.
- Response (pop) when mem_res_valid and the FIFO is non-empty:
  - ch_res_valid[head_tag] = 1 and ch_res_data = mem_res_data in the same cycle.
  - The head is popped at the clock edge.
- Orphan: mem_res_valid with outstanding == 0 is dropped. No ch_res_valid is asserted, and err_orphan is set until reset.
- outstanding <= outstanding + push - pop. Simultaneous push and pop leave it unchanged.
- The tag FIFO uses read/write pointers of $clog2(MAX_OUT) bits that wrap naturally, plus the count.
- A channel that drops valid before ready is simply not considered; nothing is latched from unaccepted requests.

## Timing
- Request path is zero-latency combinational from ch_req_* to mem_req_*. There is no registered stage.
- Response routing is zero-latency combinational from mem_res_* to ch_res_*.
- State updates on the rising edge of clk: rr_ptr, FIFO contents and pointers, outstanding, err_orphan.
- The design has no combinational loop: mem_req_ready does not feed mem_req_valid.
- Reset (synchronous) values:
  - rr_ptr=0, FIFO empty, outstanding=0, err_orphan=0.
  - All ch_req_ready=0, ch_res_valid=0, ch_res_data=0, mem_req_valid=0, mem_req_*=0, provided inputs are idle. While reset is high, ch_req_ready and mem_req_valid are forced to 0.
- Reset mid-operation discards all in-flight tags. Responses arriving after reset are treated as orphans.
- Full boundary: at outstanding == MAX_OUT, issue is allowed only in a cycle with mem_res_valid=1. That cycle pushes and pops, and the count stays MAX_OUT.
- Back-to-back accepts are allowed every cycle up to MAX_OUT.

## Test plan
- Single channel read, N_CH=2:
  - Stimulus: ch0 valid addr=0x100, fcn=0, mem_req_ready=1; 3 cycles later mem_res_valid, data=0xDEADBEEF.
  - Required: ch_req_ready[0] in the issue cycle; outstanding=1 for 3 cycles; then ch_res_valid=2'b01 with ch_res_data=0xDEADBEEF.
- Round-robin fairness:
  - Stimulus: ch0 and ch1 continuously valid, mem_req_ready=1, responses returned immediately.
  - Required: grants alternate 0,1,0,1 from reset; ARB_RR=0 grants only ch0.
- Full stall, MAX_OUT=4:
  - Stimulus: 4 accepts, no responses.
  - Required: mem_req_valid=0 on the 5th cycle and outstanding=4. The cycle mem_res_valid arrives, the next request issues and outstanding stays 4.
- Interleaved routing:
  - Stimulus: issue ch1, ch0, ch1; return data 1, 2, 3.
  - Required: ch_res_valid = 2'b10, 2'b01, 2'b10 with matching data.
- Orphan:
  - Stimulus: mem_res_valid after reset with nothing in flight.
  - Required: no ch_res_valid; err_orphan=1 and it stays set until reset.
- Reset mid-flight:
  - Stimulus: 2 outstanding, assert reset for 1 cycle.
  - Required: outstanding=0, rr_ptr=0, err_orphan=0; the next mem_res_valid sets err_orphan.
